// File: rtl/switch_counter_ctrl.sv
// ============================================================================
// Module  : switch_counter_ctrl
// Brief   : Two debounced push-buttons drive a 00..99 BCD up/down counter
//           shown on two active-low 7-segment digits, plus status LEDs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_counter_ctrl #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    output logic [6:0] o_Segment1,
    output logic [6:0] o_Segment2,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] c_cnt_max = CW'(DEBOUNCE_LIMIT - 1);
    localparam logic [6:0] c_seg_zero = 7'b0000001;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } db_state_t;

    logic [1:0] sw_raw;
    logic [1:0] press_w;
    logic [1:0] level_w;

    assign sw_raw = {i_Switch_2, i_Switch_1};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_sw
            logic          sync1_q;
            logic          sync2_q;
            db_state_t     state_q;
            db_state_t     state_d;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          state_dly_q;
            logic          press_q;
            logic          press_d;

            // Debounce next state: count differing samples, flip after the limit
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                if (sync2_q == logic'(state_q)) begin
                    cnt_d = '0;
                end else if (cnt_q == c_cnt_max) begin
                    state_d = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Press is the rising edge of the accepted level, one cycle late
                press_d = (state_q == ST_HIGH) && !state_dly_q;
            end

            // Synchronizer, debounce FSM and press-pulse registers
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    sync1_q     <= 1'b0;
                    sync2_q     <= 1'b0;
                    state_q     <= ST_LOW;
                    cnt_q       <= '0;
                    state_dly_q <= 1'b0;
                    press_q     <= 1'b0;
                end else begin
                    sync1_q     <= sw_raw[i];
                    sync2_q     <= sync1_q;
                    state_q     <= state_d;
                    cnt_q       <= cnt_d;
                    state_dly_q <= logic'(state_q);
                    press_q     <= press_d;
                end
            end

            assign press_w[i] = press_q;
            assign level_w[i] = logic'(state_q);
        end
    endgenerate

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    // BCD up/down with wrap; simultaneous presses clear the count
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (press_w[0] && press_w[1]) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (press_w[0]) begin
            if (ones_q >= 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q >= 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (press_w[1]) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    // Count registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [6:0] seg1_q, seg1_d;
    logic [6:0] seg2_q, seg2_d;
    logic       led3_q, led3_d;
    logic       led4_q, led4_d;

    // Display decode and boundary flags, registered together
    always_comb begin
        seg1_d = seg_decode(tens_q);
        seg2_d = seg_decode(ones_q);
        led3_d = (tens_q == 4'd0) && (ones_q == 4'd0);
        led4_d = (tens_q == 4'd9) && (ones_q == 4'd9);
    end

    // Output registers; reset values match a count of 00
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            seg1_q <= c_seg_zero;
            seg2_q <= c_seg_zero;
            led3_q <= 1'b1;
            led4_q <= 1'b0;
        end else begin
            seg1_q <= seg1_d;
            seg2_q <= seg2_d;
            led3_q <= led3_d;
            led4_q <= led4_d;
        end
    end

    assign o_Segment1 = seg1_q;
    assign o_Segment2 = seg2_q;
    assign o_LED_1    = level_w[0];
    assign o_LED_2    = level_w[1];
    assign o_LED_3    = led3_q;
    assign o_LED_4    = led4_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_counter_ctrl.sv
// ============================================================================
// Module  : tb_switch_counter_ctrl
// Brief   : Directed, table-driven bench for switch_counter_ctrl (limit 4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_counter_ctrl;

    localparam int c_limit = 4;

    logic       clk;
    logic       rst;
    logic       sw1;
    logic       sw2;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic       led1, led2, led3, led4;

    int n_checks = 0;
    int n_fail   = 0;

    switch_counter_ctrl #(.DEBOUNCE_LIMIT(c_limit)) u_dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Switch_1 (sw1),
        .i_Switch_2 (sw2),
        .o_Segment1 (seg1),
        .o_Segment2 (seg2),
        .o_LED_1    (led1),
        .o_LED_2    (led2),
        .o_LED_3    (led3),
        .o_LED_4    (led4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low {A..G} patterns for digits 0..9
    logic [6:0] seg_lut [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    typedef struct {
        logic s1;
        logic s2;
        int   reps;
        int   tens;
        int   ones;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_count(input string name, input int tens, input int ones);
        check({name, " seg1"}, seg1, seg_lut[tens]);
        check({name, " seg2"}, seg2, seg_lut[ones]);
        check({name, " led3"}, {6'd0, led3}, {6'd0, (tens == 0 && ones == 0)});
        check({name, " led4"}, {6'd0, led4}, {6'd0, (tens == 9 && ones == 9)});
    endtask

    // From a negedge: wait until just after posedge number n (edge 0 is next)
    task automatic after_edge(input int n);
        repeat (n + 1) @(posedge clk);
        #1;
    endtask

    // One press of the selected switches; the other switch is left untouched
    task automatic press(input logic s1, input logic s2);
        @(negedge clk);
        if (s1) sw1 = 1'b1;
        if (s2) sw2 = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        if (s1) sw1 = 1'b0;
        if (s2) sw2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_count("reset", 0, 0);
        check("reset led1", {6'd0, led1}, 7'd0);
        check("reset led2", {6'd0, led2}, 7'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{s1: 1'b0, s2: 1'b1, reps: 1,  tens: 9, ones: 9};
        vecs[1] = '{s1: 1'b1, s2: 1'b0, reps: 1,  tens: 0, ones: 0};
        vecs[2] = '{s1: 1'b1, s2: 1'b0, reps: 9,  tens: 0, ones: 9};
        vecs[3] = '{s1: 1'b1, s2: 1'b0, reps: 1,  tens: 1, ones: 0};
        vecs[4] = '{s1: 1'b1, s2: 1'b0, reps: 9,  tens: 1, ones: 9};
        vecs[5] = '{s1: 1'b0, s2: 1'b1, reps: 9,  tens: 1, ones: 0};
        vecs[6] = '{s1: 1'b0, s2: 1'b1, reps: 1,  tens: 0, ones: 9};
        vecs[7] = '{s1: 1'b1, s2: 1'b0, reps: 28, tens: 3, ones: 7};

        rst = 1'b1;
        sw1 = 1'b0;
        sw2 = 1'b0;
        #2;
        check_count("por", 0, 0);
        check("por led1", {6'd0, led1}, 7'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Held switch: count at edge 7, display at edge 8, one increment only
        @(negedge clk);
        sw1 = 1'b1;
        after_edge(4);
        check("hold led1 e4", {6'd0, led1}, 7'd0);
        after_edge(0);
        check("hold led1 e5", {6'd0, led1}, 7'd1);
        after_edge(1);
        check_count("hold e7", 0, 0);
        after_edge(0);
        check_count("hold e8", 0, 1);
        repeat (12) @(posedge clk);
        #1;
        check_count("hold end", 0, 1);
        @(negedge clk);
        sw1 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("release led1", {6'd0, led1}, 7'd0);

        // Three-cycle pulse is too short to be accepted
        @(negedge clk);
        sw1 = 1'b1;
        repeat (3) @(negedge clk);
        sw1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("short pulse led1", {6'd0, led1}, 7'd0);
        end
        check_count("short pulse", 0, 1);

        // Three-cycle low glitch inside a hold produces no extra event
        @(negedge clk);
        sw1 = 1'b1;
        repeat (12) @(negedge clk);
        sw1 = 1'b0;
        repeat (3) @(negedge clk);
        sw1 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            check("glitch led1", {6'd0, led1}, 7'd1);
        end
        check_count("glitch", 0, 2);
        @(negedge clk);
        sw1 = 1'b0;
        repeat (10) @(posedge clk);

        do_reset();

        // Table: wrap, carry, borrow and bulk counting
        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) press(vecs[v].s1, vecs[v].s2);
            check_count($sformatf("vec%0d", v), vecs[v].tens, vecs[v].ones);
        end

        // Both switches on the same edge from 37 clear the count
        @(negedge clk);
        sw1 = 1'b1;
        sw2 = 1'b1;
        after_edge(7);
        check_count("both e7", 3, 7);
        after_edge(0);
        check_count("both e8", 0, 0);
        @(negedge clk);
        sw1 = 1'b0;
        sw2 = 1'b0;
        repeat (10) @(posedge clk);

        // Switch 2 held while switch 1 keeps counting
        @(negedge clk);
        sw2 = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_count("indep hold2", 9, 9);
        check("indep led2", {6'd0, led2}, 7'd1);
        press(1'b1, 1'b0);
        check_count("indep p1", 0, 0);
        press(1'b1, 1'b0);
        check_count("indep p2", 0, 1);
        @(negedge clk);
        sw2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_count("indep rel2", 0, 1);

        // Reset mid-debounce: immediate outputs, then one fresh press
        @(negedge clk);
        sw1 = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_count("mid rst", 0, 0);
        check("mid rst led1", {6'd0, led1}, 7'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_count("post rst", 0, 1);
        check("post rst led1", {6'd0, led1}, 7'd1);
        repeat (20) @(posedge clk);
        #1;
        check_count("post rst hold", 0, 1);
        @(negedge clk);
        sw1 = 1'b0;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/switch_counter_ctrl.md
SWITCH_COUNTER_CTRL -- requirements
Module: switch_counter_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_LIMIT, default 250000: number of consecutive stable cycles needed to accept a switch level (20 ms at 12 MHz); legal range 2 or more.
REQ-002 SHALL have port i_Clk  input  1  system clock, 12 MHz; all state changes on the rising edge.
REQ-003 SHALL have port i_Rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_Switch_1  input  1  raw, asynchronous push-button level: increment request.
REQ-005 SHALL have port i_Switch_2  input  1  raw, asynchronous push-button level: decrement request.
REQ-006 SHALL have port o_Segment1  output  7  tens digit, bit order {A,B,C,D,E,F,G}, active-low.
REQ-007 SHALL have port o_Segment2  output  7  ones digit, bit order {A,B,C,D,E,F,G}, active-low.
REQ-008 SHALL have port o_LED_1  output  1  debounced level of switch 1.
REQ-009 SHALL have port o_LED_2  output  1  debounced level of switch 2.
REQ-010 SHALL have port o_LED_3  output  1  high while the count equals 00.
REQ-011 SHALL have port o_LED_4  output  1  high while the count equals 99.

Function
REQ-012 SHALL pass each switch through a 2-flop synchronizer before any other logic uses it.
REQ-013 SHALL run one debounce FSM per switch:
- States: LOW, HIGH.
- Counter width: $clog2(DEBOUNCE_LIMIT).
- Counter clears whenever the synchronized input equals the current state.
- Counter increments whenever the synchronized input differs from the current state.
REQ-014 SHALL make each debounce FSM toggle state and clear its counter on the edge where the counter equals DEBOUNCE_LIMIT-1 and the input still differs, so that exactly DEBOUNCE_LIMIT consecutive differing samples are required.
REQ-015 SHALL treat any glitch shorter than DEBOUNCE_LIMIT synchronized cycles as ignored, with no state change and no event.
REQ-016 SHALL generate a registered, one-cycle press pulse on each LOW->HIGH debounce transition, and no event on HIGH->LOW.
REQ-017 SHALL hold the count as two BCD digits, tens and ones (each 4 bits, 0-9), forming a value 00..99.
REQ-018 SHALL apply press pulses to the count as follows:
- Press 1 only: +1.
- Press 2 only: -1.
- Both pulses in the same cycle: clear to 00.
REQ-019 SHALL wrap at the boundaries: 99 + 1 -> 00, 00 - 1 -> 99.
REQ-020 SHALL carry and borrow between digits: ones 9 + 1 -> ones 0 with tens + 1; ones 0 - 1 -> ones 9 with tens - 1.
REQ-021 SHALL never let either digit register hold a value above 9.
REQ-022 SHALL decode each digit to active-low segments through registered outputs, updating one cycle after the count changes:
- 0 = 0000001
- 1 = 1001111
- 2 = 0010010
- 3 = 0000110
- 4 = 1001100
- 5 = 0100100
- 6 = 0100000
- 7 = 0001111
- 8 = 0000000
- 9 = 0000100
REQ-023 SHALL drive o_LED_1 and o_LED_2 directly from the debounce FSM states.
REQ-024 SHALL register o_LED_3 and o_LED_4 alongside the segment outputs, so they change on the same edge.
REQ-025 SHALL meet this latency: if the first clock edge that samples the raw switch high is edge 0, the count updates at edge DEBOUNCE_LIMIT+3 and the segments at edge DEBOUNCE_LIMIT+4.
REQ-026 SHALL make a held switch produce exactly one press, with no auto-repeat.
REQ-027 SHALL process each switch independently, so one switch held while the other is pressed still counts the other's presses.

Reset
REQ-028 SHALL, while i_Rst is high, asynchronously clear:
- synchronizers to 0;
- debounce states to LOW and debounce counters to 0;
- press pulses to 0;
- count to 00.
REQ-029 SHALL, while i_Rst is high, asynchronously drive the outputs to:
- o_Segment1 = o_Segment2 = 0000001;
- o_LED_1 = o_LED_2 = 0, o_LED_3 = 1, o_LED_4 = 0.
REQ-030 SHALL, if reset is asserted mid-debounce or while a switch is held, abandon that debounce entirely; a switch still held after reset release SHALL be accepted as one new press after DEBOUNCE_LIMIT stable cycles.

Verification (DEBOUNCE_LIMIT=4)
REQ-031 SHALL cover this case: reset, then hold i_Switch_1 high for 20 cycles -> count 01 at edge 7 and o_Segment2=1001111 at edge 8; o_LED_3 falls on edge 8; exactly one increment.
REQ-032 SHALL cover this case: a 3-cycle high pulse on i_Switch_1 -> no count change and o_LED_1 stays 0; with a 3-cycle glitch low in the middle of a hold, the debounce counter clears and there is no extra event.
REQ-033 SHALL cover this case: 10 presses of switch 1 from 09 -> 19, with tens carry on the 09->10 transition; from 00, one press of switch 2 -> 99, o_Segment1=o_Segment2=0000100, o_LED_4=1.
REQ-034 SHALL cover this case: from 99, one switch 1 press -> 00 with o_LED_3=1; from 10, one switch 2 press -> 09.
REQ-035 SHALL cover this case: both switches rising on the same edge from count 37 -> count 00 at edge 7, not 37.
REQ-036 SHALL cover this case: i_Rst asserted at debounce count 2 while switch 1 is held -> all outputs take reset values immediately (without a clock edge); after release with the switch still held, exactly one increment occurs, reaching 01.
